reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer that sits directly downstream of the CDB output in the superscalar core. It allocates one entry per dispatched instruction and hands the entry index back to the dispatcher as the instruction's rd tag. It captures results broadcast on the CDB and retires completed entries strictly in program order, one per cycle, to the architectural register file and the store-commit path. A flush input squashes all in-flight entries on a branch mispredict.

## Interface
- DEPTH, 16, number of entries; power of two, ≥4
- TAG_W, $clog2(DEPTH), tag width; tag = entry index
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dispatch_alloc  in  1  allocate the entry at tail this cycle
- dispatch_rd_addr  in  5  destination architectural register
- dispatch_rd_we  in  1  instruction writes rd (0 for stores/branches)
- dispatch_is_store  in  1  instruction is a store
- rob_tag  out  TAG_W  tag the next allocation receives (= tail index)
- rob_full  out  1  count == DEPTH
- rob_count  out  TAG_W+1  occupied entries
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  completing tag
- cdb_data  in  32  result
- flush  in  1  squash all entries
- retire_valid  out  1  one-cycle retire pulse
- retire_tag  out  TAG_W  retiring entry index
- retire_rd_addr  out  5  register to write
- retire_rd_we  out  1  write enable to register file (valid & rd_we & rd_addr≠0)
- retire_is_store  out  1  commit pending store
- retire_data  out  32  result value

## Operation
- Circular buffer; head/tail pointers are TAG_W+1 bits (wrap bit). full: pointers equal except wrap bit; empty: pointers equal.
- Allocate (dispatch_alloc & !rob_full): entry[tail] ← {valid=1, done=0, rd_addr, rd_we, is_store, data=0}; tail+1. Alloc while full: ignored, no state change.
- Complete (cdb_valid): if entry[cdb_tag].valid & !done → done=1, data=cdb_data. Tag of invalid or already-done entry: ignored.
- Retire: if entry[head].valid & done → outputs registered from entry[head], retire_valid=1, entry[head].valid=0, head+1. Otherwise retire_valid=0 and other retire outputs hold their last values.
- Alloc, complete and retire may all occur in one cycle; rob_count updates by +alloc −retire. Entry freed by retire is allocatable the following cycle.
- flush: highest priority. Next edge: all valid/done cleared, head=tail=0, count=0, retire_valid=0; concurrent alloc, CDB and retire are discarded.
- Reset (rst=0, async): same state as flush; all outputs 0 (rob_tag=0, rob_full=0, rob_count=0, all retire_* = 0). Reset mid-operation discards all entries.

## Timing
- rob_tag, rob_full, rob_count are registered-state combinational decodes; valid in the same cycle for the dispatcher's decision.
- CDB capture at edge E0 for the head entry → retire_valid high in the cycle after E1 (1-cycle capture-to-retire latency).
- Alloc at edge E0 → earliest CDB completion accepted at E1 → earliest retire pulse after E2.
- Throughput: one allocation and one retirement per cycle sustained.
- Back-to-back done entries retire on consecutive cycles.

## Structure
- Shared package (alongside the existing CDB/queue typedefs): rob_entry_t struct {valid, done, rd_addr[4:0], rd_we, is_store, data[31:0]}, ROB_DEPTH constant, rob_tag_t typedef.
- One sub-module: rob_ptr (TAG_W+1-bit wrap-aware incrementing pointer with sync clear, async reset), instantiated for head and tail.
- Entry array, CDB match and retire registers remain in reorder_buffer.

## Test plan
- Reset: drive rst=0 mid-traffic → all outputs 0, rob_tag=0, rob_count=0; after release, first alloc gets tag 0.
- In-order retire: alloc tags 0,1,2 (rd x5,x6,x7); CDB tag 2 data 0x22, then tag 0 data 0x10, then tag 1 data 0x11 → retires in order 0(x5,0x10),1(x6,0x11),2(x7,0x22) on consecutive cycles after tag 1 completes.
- Full/wrap: alloc 16 → rob_full=1, 17th alloc ignored; complete+retire tag 0, alloc → gets tag 0, count=16, wrap bit toggled.
- Simultaneous: at count=8, alloc + CDB on head + prior-done head retire in one cycle → count stays 8, retire_valid next cycle.
- Flush: 5 entries, 2 done, flush with concurrent alloc and CDB → next cycle count=0, retire_valid=0, rob_tag=0, later CDB tag 1 ignored.
- Edge cases: store with rd_we=1? no — store rd_we=0 retires with retire_is_store=1, retire_rd_we=0; rd_addr=0 with rd_we=1 → retire_rd_we=0; duplicate CDB tag → data unchanged.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its pointer logic.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_REG_W-1:0]  rd_addr;
    logic                  rd_we;
    logic                  is_store;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // x0 is hardwired to zero, so a write to it is never forwarded to the register file.
  function automatic logic rd_writes(input logic rd_we, input logic [ROB_REG_W-1:0] rd_addr);
    return rd_we && (rd_addr != '0);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-aware circular-buffer pointer: TAG_W index bits plus one wrap bit.
module rob_ptr #(
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           inc,
  output logic [TAG_W:0] ptr
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  // Pointer register: clear beats increment; the wrap bit toggles naturally on overflow.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, captures CDB results,
// retires completed entries in program order one per cycle, squashes on flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // Dispatch side
  input  logic                  dispatch_alloc,
  input  logic [ROB_REG_W-1:0]  dispatch_rd_addr,
  input  logic                  dispatch_rd_we,
  input  logic                  dispatch_is_store,
  output logic [TAG_W-1:0]      rob_tag,
  output logic                  rob_full,
  output logic [TAG_W:0]        rob_count,
  // Completion broadcast
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [ROB_DATA_W-1:0] cdb_data,
  // Squash
  input  logic                  flush,
  // Retire side
  output logic                  retire_valid,
  output logic [TAG_W-1:0]      retire_tag,
  output logic [ROB_REG_W-1:0]  retire_rd_addr,
  output logic                  retire_rd_we,
  output logic                  retire_is_store,
  output logic [ROB_DATA_W-1:0] retire_data
);

  logic [TAG_W:0]        head_ptr;
  logic [TAG_W:0]        tail_ptr;
  logic [TAG_W-1:0]      head_idx;
  logic [TAG_W-1:0]      tail_idx;

  // Per-entry status flags (reset) and payload (not reset).
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      done_q;
  logic [ROB_REG_W-1:0]  rd_addr_q [DEPTH];
  logic [DEPTH-1:0]      rd_we_q;
  logic [DEPTH-1:0]      is_store_q;
  logic [ROB_DATA_W-1:0] data_q    [DEPTH];

  rob_entry_t            head_entry;
  logic                  do_alloc;
  logic                  do_complete;
  logic                  do_retire;

  assign head_idx  = head_ptr[TAG_W-1:0];
  assign tail_idx  = tail_ptr[TAG_W-1:0];

  // Full when indices match but wrap bits differ; empty when pointers are identical.
  assign rob_full  = (head_ptr[TAG_W] != tail_ptr[TAG_W]) && (head_idx == tail_idx);
  assign rob_count = tail_ptr - head_ptr;
  assign rob_tag   = tail_idx;

  assign head_entry = '{
    valid:    valid_q[head_idx],
    done:     done_q[head_idx],
    rd_addr:  rd_addr_q[head_idx],
    rd_we:    rd_we_q[head_idx],
    is_store: is_store_q[head_idx],
    data:     data_q[head_idx]
  };

  // Flush overrides every other event in the same cycle. Alloc, complete and
  // retire can never target the same entry: alloc needs a free tail slot,
  // complete needs a valid not-done entry, retire needs a valid done head.
  assign do_alloc    = dispatch_alloc && !rob_full && !flush;
  assign do_complete = cdb_valid && valid_q[cdb_tag] && !done_q[cdb_tag] && !flush;
  assign do_retire   = head_entry.valid && head_entry.done && !flush;

  rob_ptr #(.TAG_W(TAG_W)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (do_retire),
    .ptr   (head_ptr)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (do_alloc),
    .ptr   (tail_ptr)
  );

  // Status flags: set valid on alloc, set done on CDB capture, clear on retire or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (do_retire) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
      end
      if (do_complete) begin
        done_q[cdb_tag] <= 1'b1;
      end
      if (do_alloc) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
      end
    end
  end

  // Payload storage: instruction fields written at alloc, result written at completion.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; valid/done gate every use, so stale contents are never observed.
    if (do_alloc) begin
      rd_addr_q[tail_idx]  <= dispatch_rd_addr;
      rd_we_q[tail_idx]    <= dispatch_rd_we;
      is_store_q[tail_idx] <= dispatch_is_store;
      data_q[tail_idx]     <= '0;
    end
    if (do_complete) begin
      data_q[cdb_tag] <= cdb_data;
    end
  end

  // Retire registers: pulse valid for one cycle, hold the last retired fields otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_valid    <= 1'b0;
      retire_tag      <= '0;
      retire_rd_addr  <= '0;
      retire_rd_we    <= 1'b0;
      retire_is_store <= 1'b0;
      retire_data     <= '0;
    end else begin
      retire_valid <= do_retire;
      if (do_retire) begin
        retire_tag      <= head_idx;
        retire_rd_addr  <= head_entry.rd_addr;
        retire_rd_we    <= rd_writes(head_entry.rd_we, head_entry.rd_addr);
        retire_is_store <= head_entry.is_store;
        retire_data     <= head_entry.data;
      end
    end
  end

endmodule
